// File: rtl/fetch_stage.sv
// fetch_stage: IF stage. Generates the PC, fetches over a single-outstanding
// req/ack instruction port and drives the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_INC    = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        KILL  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] kill_addr;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        ack;

    // Ack only counts while we are actually requesting.
    assign ack    = imemReq & imemAck;
    assign pc_inc = pc + PC_INC;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    // Next-state logic; a branch in KILL keeps the wrong-path request alive.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (branchTaken)        state_next = ack ? FETCH : KILL;
                else if (ack && freeze) state_next = HOLD;
            end
            KILL:    if (!branchTaken && ack)      state_next = FETCH;
            HOLD:    if (branchTaken || !freeze)   state_next = FETCH;
            default:                               state_next = FETCH;
        endcase
    end

    // Memory port outputs; KILL keeps the abandoned address stable until ack.
    always_comb begin
        imemReq  = (state != HOLD);
        imemAddr = (state == KILL) ? kill_addr : pc;
    end

    // Fetch address, kill address and the freeze hold buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            kill_addr  <= '0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            if (branchTaken)                 pc <= branchAddr;
            else if (state == FETCH && ack)  pc <= pc_inc;

            if (state == FETCH && branchTaken && !ack)
                kill_addr <= pc;

            if (state == FETCH && ack && freeze && !branchTaken) begin
                hold_pc    <= pc_inc;
                hold_instr <= imemData;
            end
        end
    end

    // IF/ID register: flush beats freeze beats load/bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC          <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (branchTaken) begin
            PC          <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else if (freeze) begin
            PC          <= PC;
            instruction <= instruction;
            valid       <= valid;
        end else if (state == FETCH && ack) begin
            PC          <= pc_inc;
            instruction <= imemData;
            valid       <= 1'b1;
        end else if (state == HOLD) begin
            PC          <= hold_pc;
            instruction <= hold_instr;
            valid       <= 1'b1;
        end else begin
            PC          <= '0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic, every cycle checked
// against a transaction-level model (pending request, wrong-path flag, hold queue).
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, branchTaken, imemAck;
    logic [31:0] branchAddr, imemData;
    logic        imemReq, valid;
    logic [31:0] imemAddr, PC, instruction;

    int vectors = 0;
    int miscompares = 0;

    fetch_stage #(.RESET_PC(RESET_PC), .PC_INC(PC_INC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branchTaken(branchTaken),
        .branchAddr(branchAddr), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemAck(imemAck), .imemData(imemData), .PC(PC),
        .instruction(instruction), .valid(valid)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [31:0] m_pc, m_kaddr;
    bit          m_wrong;          // current request is a squashed wrong-path fetch
    logic [63:0] m_q[$];           // words fetched during freeze, {pc, instr}
    logic [31:0] m_PC, m_ins;
    logic        m_vld;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc = RESET_PC; m_kaddr = '0; m_wrong = 0; m_q.delete();
        m_PC = '0; m_ins = NOP_INSTR; m_vld = 0;
    endtask

    task automatic check_outs();
        bit exp_req;
        exp_req = (m_q.size() == 0);
        chk("imemReq", {31'd0, imemReq}, {31'd0, exp_req});
        if (exp_req) chk("imemAddr", imemAddr, m_wrong ? m_kaddr : m_pc);
        chk("PC", PC, m_PC);
        chk("instruction", instruction, m_ins);
        chk("valid", {31'd0, valid}, {31'd0, m_vld});
    endtask

    // Called at a negedge: drive, check, then advance the model across the posedge.
    task automatic step(input bit a, input bit f, input bit b, input logic [31:0] ba);
        bit          req, accepted, have_word;
        logic [63:0] word;
        imemAck = a; freeze = f; branchTaken = b; branchAddr = ba; imemData = $urandom;
        #1 check_outs();
        @(posedge clk);
        req       = (m_q.size() == 0);
        accepted  = req && a;
        have_word = accepted && !m_wrong;
        word      = {m_pc + PC_INC, imemData};
        if (b) begin
            m_PC = '0; m_ins = NOP_INSTR; m_vld = 0;
            m_q.delete();
            if (req && !accepted && !m_wrong) begin
                m_wrong = 1; m_kaddr = m_pc;
            end
            m_pc = ba;
        end else begin
            if (m_wrong && accepted) m_wrong = 0;
            if (have_word) begin
                m_pc = m_pc + PC_INC;
                if (f) m_q.push_back(word);
                else {m_PC, m_ins, m_vld} = {word, 1'b1};
            end else if (!f) begin
                if (m_q.size() != 0) {m_PC, m_ins, m_vld} = {m_q.pop_front(), 1'b1};
                else begin m_PC = '0; m_ins = NOP_INSTR; m_vld = 0; end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; freeze = 0; branchTaken = 0; branchAddr = '0; imemAck = 0; imemData = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // zero-wait streaming
        repeat (4) step(1, 0, 0, 0);
        // two wait states then ack
        step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0);
        // freeze across an ack, three cycles, then release
        step(1, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        step(0, 0, 0, 0); step(1, 0, 0, 0);
        // branch while a request waits: kill then redirect
        step(0, 0, 1, 32'h100); step(0, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
        // branch together with freeze while in HOLD
        step(1, 1, 0, 0); step(0, 1, 1, 32'h300); step(1, 0, 0, 0);
        // second branch in KILL, then one coinciding with the kill ack
        step(0, 0, 1, 32'h100); step(0, 0, 1, 32'h200); step(1, 0, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 1, 32'h400); step(1, 0, 1, 32'h500); step(1, 0, 0, 0); step(1, 0, 0, 0);
        // wrap of the fetch address, unaligned target too
        step(1, 0, 1, 32'hFFFF_FFFC); step(1, 0, 0, 0);
        chk("wrap_PC", PC, 32'h0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0102); step(1, 0, 0, 0); step(1, 0, 0, 0);

        // async reset mid-wait, between clock edges
        step(1, 0, 0, 0); step(0, 0, 0, 0);
        imemAck = 0; #1 rst = 1'b0; #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_PC", PC, 32'd0);
        chk("rst_instruction", instruction, NOP_INSTR);
        m_reset();
        @(negedge clk); rst = 1'b1;
        #1 chk("rst_first_addr", imemAddr, RESET_PC);
        @(negedge clk);
        // the extra half cycle above had ack=0 and no branch/freeze: IF/ID bubble, pc held
        m_PC = '0; m_ins = NOP_INSTR; m_vld = 0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 1023), 2'b00};
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 10, ba);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Producer end of the IF→ID interface. Generates the PC and fetches instructions over a req/ack instruction-memory port.
- Presents {PC, instruction, valid} to the decode stage through an internal IF/ID pipeline register.
- Honours freeze (hazard stall) and branchTaken (redirect plus flush of the IF/ID register).
- Allows one outstanding memory request. A response already in flight when a branch arrives is discarded through a kill state.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- PC_INC, 4, byte increment between sequential fetches.
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on bubble or flush.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- freeze  input  1  hazard stall; hold the IF/ID register and do not advance it.
- branchTaken  input  1  redirect request from EXE; also flushes IF/ID.
- branchAddr  input  32  redirect target; sampled when branchTaken=1.
- imemReq  output  1  instruction-memory request.
- imemAddr  output  32  request address; stable while imemReq=1 and imemAck=0.
- imemAck  input  1  memory accepts the request and returns data in the same cycle; qualified by imemReq.
- imemData  input  32  instruction word; valid when imemAck=1.
- PC  output  32  IF/ID: fetch address + PC_INC.
- instruction  output  32  IF/ID instruction word.
- valid  output  1  IF/ID holds a real instruction (0 = bubble).

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=FETCH, PC=0, instruction=NOP_INSTR, valid=0, hold buffer cleared. A request in flight is abandoned.
- imemReq is 1 in FETCH and KILL, 0 in HOLD.
- imemAddr is pc in FETCH and killAddr in KILL.
- IF/ID update priority, highest first:
  1. branchTaken: flush to {0, NOP_INSTR, 0}.
  2. freeze: hold the current value.
  3. Load new data, or a bubble if no instruction is available.
- FETCH:
  - ack, no branch, no freeze: IF/ID <= {pc+PC_INC, imemData, 1}; pc <= pc+PC_INC; stay in FETCH.
  - ack, freeze, no branch: holdInstr <= imemData; holdPC <= pc+PC_INC; pc <= pc+PC_INC; go to HOLD.
  - branchTaken with ack: drop the data; pc <= branchAddr; stay in FETCH.
  - branchTaken without ack: killAddr <= pc; pc <= branchAddr; go to KILL.
  - no ack, no branch: pc unchanged; IF/ID gets a bubble unless freeze.
- KILL:
  - imemReq=1 with imemAddr=killAddr until ack. The protocol forbids changing the address mid-request.
  - On ack: discard the data and go to FETCH. The next request uses pc.
  - branchTaken in KILL: pc <= branchAddr and stay in KILL. The latest branch wins, including when it coincides with ack.
  - IF/ID gets a bubble unless freeze (a flush takes precedence).
- HOLD:
  - No request is issued.
  - !freeze: IF/ID <= {holdPC, holdInstr, 1}; go to FETCH.
  - branchTaken: discard the buffer; pc <= branchAddr; flush IF/ID; go to FETCH.
- Arithmetic: pc+PC_INC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). branchAddr is used unaligned as given.
- Throughput: 1 instruction per cycle when imemAck is tied high and there is no freeze. Latency is 1 cycle from ack to IF/ID valid.
- No instruction is lost or duplicated across freeze, and none across branches except deliberately squashed wrong-path words.

Test Plan:
- Zero-wait memory (ack=1 constantly), RESET_PC=0, 4 cycles → IF/ID shows {4,I0},{8,I1},{12,I2},{16,I3}, valid=1 each; imemAddr 0,4,8,12.
- Memory with 2-cycle wait states → imemAddr stable at 0 until ack, IF/ID valid=0 during waits, then {4,I0}; next request at 4.
- freeze=1 for 3 cycles when ack at addr 8 → IF/ID holds {8,I1}, no request while in HOLD; after release IF/ID={12,I2} exactly once, then addr 12 is fetched.
- branchTaken=1, branchAddr=0x100 while the request at 0x10 is waiting → imemAddr stays 0x10 until ack, data dropped, next imemAddr=0x100; IF/ID flushed (valid=0, instruction=NOP_INSTR, PC=0).
- branchTaken and freeze asserted together in HOLD → buffer discarded, IF/ID flushed, next fetch at branchAddr; also cover a second branch in KILL to 0x200 → fetch resumes at 0x200.
- rst driven low asynchronously mid-wait (between edges) → outputs reset immediately (valid=0, PC=0, instruction=NOP_INSTR); after release the first imemAddr is RESET_PC. Separately, pc=0xFFFF_FFFC fetch → IF/ID PC=0, next imemAddr=0.
